// File: rtl/tx_flow_scheduler_pkg.sv
// Shared TX scheduler types: CCI-P line-length encoding, scheduler state and
// the batch-size decode also used by the transmitter.
package tx_flow_scheduler_pkg;

  localparam int LMAX_CCIP_BATCH_DEFAULT = 2;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic {
    TX_SCHED_IDLE  = 1'b0,
    TX_SCHED_BURST = 1'b1
  } tx_sched_state_e;

  typedef struct packed {
    logic [2:0]  n;
    t_ccip_clLen cl_len;
  } tx_batch_cfg_t;

  // Log2 batch size to beat count and line length; anything above 4 lines clamps.
  function automatic tx_batch_cfg_t decode_tx_batch(input int unsigned l_log);
    tx_batch_cfg_t cfg;
    case (l_log)
      0:       begin cfg.n = 3'd1; cfg.cl_len = eCL_LEN_1; end
      1:       begin cfg.n = 3'd2; cfg.cl_len = eCL_LEN_2; end
      default: begin cfg.n = 3'd4; cfg.cl_len = eCL_LEN_4; end
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/tx_flow_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter over requesters 0..i_limit; the search starts
// one past i_ptr (the previous grant, held by the parent) and wraps at i_limit.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_gnt_idx,
  output logic         o_gnt_valid
);

  int w_start;
  int w_lim;
  int w_idx;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    w_lim       = int'(i_limit);
    w_start     = (int'(i_ptr) >= w_lim) ? 0 : int'(i_ptr) + 1;
    w_idx       = 0;
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = w_start + k;
      if (w_idx > w_lim) w_idx = w_idx - (w_lim + 1);
      if (w_idx <= w_lim && i_req[W'(w_idx)]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/tx_flow_scheduler.sv
// Per-flow occupancy counting and round-robin batch scheduling for the CCI-P TX
// path: a granted flow receives one contiguous burst of N pop strobes.
module tx_flow_scheduler
  import tx_flow_scheduler_pkg::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LTX_FIFO_DEPTH    = 3,
  parameter int LMAX_CCIP_BATCH   = LMAX_CCIP_BATCH_DEFAULT
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                  number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]                    l_tx_batch_size,
  input  logic                                          sRx_c1TxAlmFull,
  input  logic                                          push_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0]                  push_flow_id,
  output logic                                          pop_en,
  output logic [LMAX_NUM_OF_FLOWS-1:0]                  pop_flow_id,
  output logic [LMAX_CCIP_BATCH:0]                      pop_idx,
  output logic                                          pop_sop,
  output logic                                          pop_eop,
  output logic [1:0]                                    burst_cl_len,
  output logic                                          busy,
  output logic                                          drop,
  output tx_sched_state_e                               dbg_state,
  output logic [2**LMAX_NUM_OF_FLOWS-1:0][LTX_FIFO_DEPTH:0] dbg_count
);

  localparam int NF = 2 ** LMAX_NUM_OF_FLOWS;
  localparam int LF = LMAX_NUM_OF_FLOWS;
  localparam int CW = LTX_FIFO_DEPTH + 1;
  localparam int IW = LMAX_CCIP_BATCH + 1;
  localparam logic [CW-1:0] FULL = CW'(2 ** LTX_FIFO_DEPTH);

  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [CW-1:0]   r_count [NF];
  logic            r_drop;
  logic [NF-1:0]   w_inc;
  logic [NF-1:0]   w_dec;
  logic [NF-1:0]   w_req;
  tx_batch_cfg_t   w_cfg;
  logic [LF-1:0]   w_gnt_idx;
  logic            w_gnt_valid;
  tx_sched_state_e r_state;
  tx_sched_state_e w_state_nxt;
  logic            w_grant;
  logic            w_last_beat;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_n;
  logic [LF-1:0]   r_flow;
  logic [LF-1:0]   r_last_grant;
  t_ccip_clLen     r_cl_len;

  // Assertion is immediate; release reaches the logic two clock edges later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_cfg = decode_tx_batch(32'(l_tx_batch_size));

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_req = '0;
    for (int f = 0; f < NF; f++) begin
      w_inc[f] = push_valid && (push_flow_id == LF'(f));
      w_dec[f] = pop_en && (pop_flow_id == LF'(f));
      w_req[f] = (LF'(f) <= number_of_flows) && (32'(r_count[f]) >= 32'(w_cfg.n));
    end
  end

  // A simultaneous push and pop on one flow cancel; a lone push to a full flow is dropped.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int f = 0; f < NF; f++) r_count[f] <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      for (int f = 0; f < NF; f++) begin
        if (w_inc[f] && !w_dec[f]) begin
          if (r_count[f] == FULL) r_drop <= 1'b1;
          else                    r_count[f] <= r_count[f] + 1'b1;
        end else if (w_dec[f] && !w_inc[f]) begin
          r_count[f] <= r_count[f] - 1'b1;
        end
      end
    end
  end

  rr_arbiter #(.N(NF), .W(LF)) u_rr_arbiter (
    .i_req       (w_req),
    .i_ptr       (r_last_grant),
    .i_limit     (number_of_flows),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_last_beat = (r_idx == r_n - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      TX_SCHED_IDLE: begin
        if (start && !sRx_c1TxAlmFull && w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = TX_SCHED_BURST;
        end
      end
      TX_SCHED_BURST: begin
        if (w_last_beat) w_state_nxt = TX_SCHED_IDLE;
      end
    endcase
  end

  // Burst parameters are frozen at grant so config changes only affect later bursts.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= TX_SCHED_IDLE;
      r_idx        <= '0;
      r_n          <= IW'(1);
      r_flow       <= '0;
      r_last_grant <= '1;
      r_cl_len     <= eCL_LEN_1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_flow       <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
        r_n          <= IW'(w_cfg.n);
        r_cl_len     <= w_cfg.cl_len;
        r_idx        <= '0;
      end else if (r_state == TX_SCHED_BURST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy         = (r_state == TX_SCHED_BURST);
  assign pop_en       = busy;
  assign pop_flow_id  = r_flow;
  assign pop_idx      = r_idx;
  assign pop_sop      = busy && (r_idx == '0);
  assign pop_eop      = busy && w_last_beat;
  assign burst_cl_len = r_cl_len;
  assign drop         = r_drop;
  assign dbg_state    = r_state;

  always_comb begin
    for (int f = 0; f < NF; f++) dbg_count[f] = r_count[f];
  end

endmodule

// File: doc/tx_flow_scheduler.md
# tx_flow_scheduler

Batch scheduler for the CCI-P TX path. Keeps a per-flow occupancy count of queued requests and selects, round-robin, a flow holding at least one full batch. It then emits a contiguous burst of per-entry pop strobes with SOP/EOP and beat index for the flow-FIFO/request-queue datapath. New bursts are gated on `sRx_c1TxAlmFull`, so multi-line `eREQ_WRLINE_I` writes are never started into a nearly full channel.

## Interface
Parameters:
- `LMAX_NUM_OF_FLOWS`, default 1: log2 of the number of flows. `MAX_TX_FLOWS = 2**LMAX_NUM_OF_FLOWS`.
- `LTX_FIFO_DEPTH`, default 3: log2 of the per-flow FIFO depth. Count width is `LTX_FIFO_DEPTH+1`.
- `LMAX_CCIP_BATCH`, default 2: width of the log batch-size config.

Ports:
- `clk` in, 1: sole clock.
- `resetn` in, 1: asynchronous, active-low reset.
- `start` in, 1: enables new bursts.
- `number_of_flows` in, `LMAX_NUM_OF_FLOWS`: index of the highest active flow.
- `l_tx_batch_size` in, `LMAX_CCIP_BATCH`: log2 of the batch size. 0→1, 1→2, 2→4, values ≥3 clamp to 4.
- `sRx_c1TxAlmFull` in, 1: CCI-P C1 almost-full.
- `push_valid` in, 1: one request enqueued.
- `push_flow_id` in, `LMAX_NUM_OF_FLOWS`: flow of the push.
- `pop_en` out, 1: pop one entry from flow `pop_flow_id`.
- `pop_flow_id` out, `LMAX_NUM_OF_FLOWS`: burst flow.
- `pop_idx` out, `LMAX_CCIP_BATCH+1`: beat index within the burst.
- `pop_sop` out, 1: first beat of the burst.
- `pop_eop` out, 1: last beat of the burst.
- `burst_cl_len` out, 2: latched `t_ccip_clLen` for the current burst.
- `busy` out, 1: burst in progress.
- `drop` out, 1: one-cycle pulse when a push hits a full flow.

## Operation
- Occupancy count per flow:
  - `push_valid` increments the count of `push_flow_id`.
  - `pop_en` decrements the count of `pop_flow_id`.
  - A push and a pop on the same flow in the same cycle leave the count unchanged.
- Overflow: a push to a flow whose count is `2**LTX_FIFO_DEPTH` (and is not being popped that cycle) does not increment and pulses `drop` for one cycle.
- Eligibility: flow f is eligible when f ≤ `number_of_flows` and count[f] ≥ N, where N is the decoded batch size. Flows above `number_of_flows` keep counting but are never granted.
- Arbitration:
  - Round-robin search starting at `last_grant+1`, wrapping at `number_of_flows` back to 0.
  - `last_grant` updates on each grant.
  - Reset value of `last_grant` is `MAX_TX_FLOWS-1`, so flow 0 has first priority.
- States:
  - **IDLE**: if `start` && !`sRx_c1TxAlmFull` && any flow is eligible, then grant. On grant, latch the flow, N and `burst_cl_len` (`eCL_LEN_1/2/4`) and go to BURST. Otherwise stay in IDLE.
  - **BURST**: `pop_en`=1 every cycle. `pop_idx` runs 0..N-1. `pop_sop` is set at idx 0 and `pop_eop` at idx N-1. After the eop beat, return to IDLE.
- A burst always completes once started, regardless of `sRx_c1TxAlmFull`, `start` or config changes. Config changes take effect at the next grant.
- `busy` = (state == BURST).

## Timing
- Grant decided in IDLE at cycle t. First `pop_en` is registered and appears at t+1. Beats are consecutive with no gaps.
- After the eop beat, at least one IDLE cycle follows before the next sop. Peak throughput is N pops per N+1 cycles.
- Counts are registered: a push at cycle t contributes to eligibility at t+1. A pop's decrement is visible at the cycle after the pop.
- `sRx_c1TxAlmFull` and `start` are sampled only in IDLE.
- Asynchronous reset (`resetn`=0) takes effect immediately, mid-burst included:
  - state returns to IDLE;
  - all counts, `pop_*`, `busy` and `drop` go to 0;
  - `burst_cl_len` goes to `eCL_LEN_1`.
- Reset release is synchronous to `clk` through the standard reset synchronizer.

## Structure
- `nic_defs.vh` holds `LMAX_CCIP_BATCH` and gains a shared typedef for the TX scheduler state enum (IDLE/BURST).
- The batch-size decode (log2 value → N and cl_len) lives in the same shared package for reuse by `ccip_transmitter`.
- Sub-module: `rr_arbiter`, a parameterized round-robin arbiter with request vector, pointer and limit in, grant index and grant-valid out. It is combinational; the pointer is held in the parent.

## Test plan
- **Single flow, batch 1:** `l_tx_batch_size`=0. Three pushes to flow 0 → three one-beat bursts (sop=eop=1, idx 0), each separated by at least one IDLE cycle; final count 0.
- **Round-robin, batch 4:** `number_of_flows`=1, `l_tx_batch_size`=2. Four pushes each to flows 0 and 1 → burst on flow 0 (idx 0..3, `burst_cl_len`=`eCL_LEN_4`), then burst on flow 1.
- **Partial batch:** batch 2 with only one entry in flow 1 → no `pop_en`. A second push to flow 1 → burst starts at two cycles after that push.
- **AlmFull gating:** eligible flow with `sRx_c1TxAlmFull`=1 → stays IDLE. AlmFull rising mid-burst → the burst still completes all N beats.
- **Overflow:** nine pushes to flow 0 with depth 8 and `start`=0 → count 8, `drop` pulses once on the 9th push. A push and pop on the same flow in the same cycle → count unchanged.
- **Reset mid-burst:** `resetn` asserted at idx 1 of a 4-beat burst → `pop_en`, `busy` and all counts are 0 in the same cycle; no pops occur after release until a new eligible batch exists.
